// File: rtl/tpu_pkg.sv
// Shared opcodes, instruction field positions and sequencer state type for the Mini TPU.
package tpu_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD_A = 2'b01;
  localparam logic [1:0] OP_LOAD_B = 2'b10;
  localparam logic [1:0] OP_CTRL   = 2'b11;

  localparam logic SUB_COMPUTE = 1'b0;
  localparam logic SUB_OUTPUT  = 1'b1;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} seq_state_t;

  // A single-lane array still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(2 * n);
  endfunction

  function automatic int unsigned op_lsb(input int unsigned iw);
    return iw - 2;
  endfunction

  function automatic int unsigned sub_pos(input int unsigned iw);
    return iw - 3;
  endfunction

  function automatic int unsigned line_lsb(input int unsigned iw, input int unsigned idx_w);
    return iw - 2 - idx_w;
  endfunction

  function automatic int unsigned elem_lsb(input int unsigned iw, input int unsigned idx_w);
    return iw - 2 - 2 * idx_w;
  endfunction

endpackage

// File: rtl/tpu_sequencer_skew.sv
// Skewed operand-feed generator: lane i reads element t-i while i <= t < i+ARRAY_N.
module tpu_skew_gen
  import tpu_pkg::*;
#(
  parameter int unsigned ARRAY_N = 4
) (
  input  logic                                    active,
  input  logic [cnt_width(ARRAY_N)-1:0]           t,
  output logic [ARRAY_N-1:0]                      read_enable,
  output logic [ARRAY_N*idx_width(ARRAY_N)-1:0]   read_elem
);

  localparam int unsigned IDX_W = idx_width(ARRAY_N);

  always_comb begin
    read_enable = '0;
    read_elem   = '0;
    for (int i = 0; i < ARRAY_N; i++) begin
      if (active && (int'(t) >= i) && (int'(t) < i + int'(ARRAY_N))) begin
        read_enable[i]              = 1'b1;
        read_elem[i*IDX_W +: IDX_W] = IDX_W'(int'(t) - i);
      end
    end
  end

endmodule

// File: rtl/tpu_sequencer.sv
// Mini TPU instruction decoder / compute sequencer. Optional feature macro: TPU_ACC_CLEAR_EN
// (adds array_clear and a one-cycle CLEAR state ahead of FEED for COMPUTE with instr[0]=1).
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned ARRAY_N     = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   instr_valid,
  input  logic [INSTR_WIDTH-1:0]                 instr,
  output logic                                   instr_ready,
  output logic                                   busy,
  output logic                                   done,
`ifdef TPU_ACC_CLEAR_EN
  output logic                                   array_clear,
`endif
  output logic                                   array_write_enable,
  output logic [idx_width(ARRAY_N)-1:0]          array_output_row,
  output logic [idx_width(ARRAY_N)-1:0]          array_output_column,
  output logic                                   mema_write_enable,
  output logic [idx_width(ARRAY_N)-1:0]          mema_write_line,
  output logic [idx_width(ARRAY_N)-1:0]          mema_write_elem,
  output logic [DATA_WIDTH-1:0]                  mema_data_in,
  output logic                                   memb_write_enable,
  output logic [idx_width(ARRAY_N)-1:0]          memb_write_line,
  output logic [idx_width(ARRAY_N)-1:0]          memb_write_elem,
  output logic [DATA_WIDTH-1:0]                  memb_data_in,
  output logic [ARRAY_N-1:0]                     mema_read_enable,
  output logic [ARRAY_N*idx_width(ARRAY_N)-1:0]  mema_read_elem,
  output logic [ARRAY_N-1:0]                     memb_read_enable,
  output logic [ARRAY_N*idx_width(ARRAY_N)-1:0]  memb_read_elem
);

  localparam int unsigned IDX_W    = idx_width(ARRAY_N);
  localparam int unsigned CNT_W    = cnt_width(ARRAY_N);
  localparam int unsigned OP_LSB   = op_lsb(INSTR_WIDTH);
  localparam int unsigned SUB_POS  = sub_pos(INSTR_WIDTH);
  localparam int unsigned LINE_LSB = line_lsb(INSTR_WIDTH, IDX_W);
  localparam int unsigned ELEM_LSB = elem_lsb(INSTR_WIDTH, IDX_W);

  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2 * ARRAY_N - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ARRAY_N - 1);

  // Decoded instruction fields
  logic [1:0]            op;
  logic                  sub;
  logic [IDX_W-1:0]      f_line;
  logic [IDX_W-1:0]      f_elem;
  logic [DATA_WIDTH-1:0] f_data;
  logic                  unused_instr;

  assign op           = instr[OP_LSB +: 2];
  assign sub          = instr[SUB_POS];
  assign f_line       = instr[LINE_LSB +: IDX_W];
  assign f_elem       = instr[ELEM_LSB +: IDX_W];
  assign f_data       = instr[DATA_WIDTH-1:0];
  assign unused_instr = ^instr;

  seq_state_t              state_q, state_d;
  logic [CNT_W-1:0]        t_q, t_d;
  logic                    ready_q, busy_q, done_q, arr_we_q, clear_q;
  logic [IDX_W-1:0]        row_q, col_q;
  logic                    mema_we_q, memb_we_q;
  logic [IDX_W-1:0]        mema_line_q, mema_elem_q, memb_line_q, memb_elem_q;
  logic [DATA_WIDTH-1:0]   mema_data_q, memb_data_q;
  logic [ARRAY_N-1:0]      rd_en_q;
  logic [ARRAY_N*IDX_W-1:0] rd_elem_q;

  logic                    fire;
  logic                    start_clear;
  logic [ARRAY_N-1:0]      skew_en;
  logic [ARRAY_N*IDX_W-1:0] skew_elem;

  // ready_q is only ever high while IDLE, so a transfer can only happen there.
  assign fire = instr_valid && ready_q;

`ifdef TPU_ACC_CLEAR_EN
  assign start_clear = instr[0];
`else
  assign start_clear = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      IDLE: begin
        if (fire && (op == OP_CTRL) && (sub == SUB_COMPUTE)) begin
          state_d = start_clear ? CLEAR : FEED;
          t_d     = '0;
        end
      end
      CLEAR: begin
        state_d = FEED;
        t_d     = '0;
      end
      FEED: begin
        if (t_q == FEED_LAST) begin
          state_d = DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      DRAIN: begin
        if (t_q == DRAIN_LAST) begin
          state_d = DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Driven from next-state so the registered lane outputs line up with the state they describe.
  tpu_skew_gen #(
    .ARRAY_N(ARRAY_N)
  ) u_skew (
    .active      (state_d == FEED),
    .t           (t_d),
    .read_enable (skew_en),
    .read_elem   (skew_elem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      t_q         <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      arr_we_q    <= 1'b0;
      clear_q     <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      mema_we_q   <= 1'b0;
      mema_line_q <= '0;
      mema_elem_q <= '0;
      mema_data_q <= '0;
      memb_we_q   <= 1'b0;
      memb_line_q <= '0;
      memb_elem_q <= '0;
      memb_data_q <= '0;
      rd_en_q     <= '0;
      rd_elem_q   <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      ready_q   <= (state_d == IDLE);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      arr_we_q  <= (state_d == FEED) || (state_d == DRAIN);
      clear_q   <= (state_d == CLEAR);
      rd_en_q   <= skew_en;
      rd_elem_q <= skew_elem;

      mema_we_q <= fire && (op == OP_LOAD_A);
      memb_we_q <= fire && (op == OP_LOAD_B);
      if (fire && (op == OP_LOAD_A)) begin
        mema_line_q <= f_line;
        mema_elem_q <= f_elem;
        mema_data_q <= f_data;
      end
      if (fire && (op == OP_LOAD_B)) begin
        memb_line_q <= f_line;
        memb_elem_q <= f_elem;
        memb_data_q <= f_data;
      end
      if (fire && (op == OP_CTRL) && (sub == SUB_OUTPUT)) begin
        row_q <= f_line;
        col_q <= f_elem;
      end
    end
  end

  assign instr_ready         = ready_q;
  assign busy                = busy_q;
  assign done                = done_q;
`ifdef TPU_ACC_CLEAR_EN
  assign array_clear         = clear_q;
`endif
  assign array_write_enable  = arr_we_q;
  assign array_output_row    = row_q;
  assign array_output_column = col_q;
  assign mema_write_enable   = mema_we_q;
  assign mema_write_line     = mema_line_q;
  assign mema_write_elem     = mema_elem_q;
  assign mema_data_in        = mema_data_q;
  assign memb_write_enable   = memb_we_q;
  assign memb_write_line     = memb_line_q;
  assign memb_write_elem     = memb_elem_q;
  assign memb_data_in        = memb_data_q;
  // A and B lanes are fed identically.
  assign mema_read_enable    = rd_en_q;
  assign mema_read_elem      = rd_elem_q;
  assign memb_read_enable    = rd_en_q;
  assign memb_read_elem      = rd_elem_q;

`ifndef TPU_ACC_CLEAR_EN
  logic unused_clear;
  assign unused_clear = clear_q;
`endif

endmodule

// File: tb/tb_tpu_sequencer.sv
// Scoreboard bench for tpu_sequencer: driver pushes expected events, negedge monitor pops and compares.
module tb_tpu_sequencer;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int IW   = 16;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            instr_valid = 1'b0;
  logic [IW-1:0]   instr = '0;
  logic            instr_ready, busy, done, array_write_enable;
  logic            array_clear_w;
  logic [IDXW-1:0] array_output_row, array_output_column;
  logic            mema_write_enable, memb_write_enable;
  logic [IDXW-1:0] mema_write_line, mema_write_elem, memb_write_line, memb_write_elem;
  logic [DW-1:0]   mema_data_in, memb_data_in;
  logic [N-1:0]    mema_read_enable, memb_read_enable;
  logic [N*IDXW-1:0] mema_read_elem, memb_read_elem;

`ifdef TPU_ACC_CLEAR_EN
  logic array_clear;
  assign array_clear_w = array_clear;
`else
  assign array_clear_w = 1'b0;
`endif

  tpu_sequencer #(
    .ARRAY_N(N), .DATA_WIDTH(DW), .INSTR_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .busy(busy), .done(done),
`ifdef TPU_ACC_CLEAR_EN
    .array_clear(array_clear),
`endif
    .array_write_enable(array_write_enable),
    .array_output_row(array_output_row), .array_output_column(array_output_column),
    .mema_write_enable(mema_write_enable), .mema_write_line(mema_write_line),
    .mema_write_elem(mema_write_elem), .mema_data_in(mema_data_in),
    .memb_write_enable(memb_write_enable), .memb_write_line(memb_write_line),
    .memb_write_elem(memb_write_elem), .memb_data_in(memb_data_in),
    .mema_read_enable(mema_read_enable), .mema_read_elem(mema_read_elem),
    .memb_read_enable(memb_read_enable), .memb_read_elem(memb_read_elem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int line; int elem; int data; } wr_t;
  typedef struct { int cyc; int row; int col; } out_t;
  typedef struct { int cyc; bit we; bit dn; bit clr; int en; int elems; } ctl_t;

  wr_t  q_a[$];
  wr_t  q_b[$];
  out_t q_out[$];
  ctl_t q_ctl[$];
  int   exp_row = 0, exp_col = 0;
  int   n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit clr_bit(input logic [IW-1:0] w);
`ifdef TPU_ACC_CLEAR_EN
    return w[0];
`else
    return 1'b0;
`endif
  endfunction

  // Reference: whole COMPUTE timeline from the feed rule, one entry per cycle from transfer edge e.
  task automatic push_compute(input int e, input bit clr);
    int c = e;
    if (clr) begin
      q_ctl.push_back('{cyc: c, we: 0, dn: 0, clr: 1, en: 0, elems: 0});
      c++;
    end
    for (int t = 0; t <= 2 * N - 2; t++) begin
      int en = 0, el = 0;
      for (int i = 0; i < N; i++)
        if (i <= t && t < i + N) begin
          en = en | (1 << i);
          el = el | ((t - i) << (i * IDXW));
        end
      q_ctl.push_back('{cyc: c, we: 1, dn: 0, clr: 0, en: en, elems: el});
      c++;
    end
    for (int d = 0; d < N; d++) begin
      q_ctl.push_back('{cyc: c, we: 1, dn: 0, clr: 0, en: 0, elems: 0});
      c++;
    end
    q_ctl.push_back('{cyc: c, we: 0, dn: 1, clr: 0, en: 0, elems: 0});
  endtask

  task automatic model(input logic [IW-1:0] w, input int e);
    int op   = (w >> (IW - 2)) & 3;
    int sub  = (w >> (IW - 3)) & 1;
    int line = (w >> (IW - 2 - IDXW)) & (N - 1);
    int elem = (w >> (IW - 2 - 2 * IDXW)) & (N - 1);
    int data = w & ((1 << DW) - 1);
    case (op)
      1: q_a.push_back('{cyc: e, line: line, elem: elem, data: data});
      2: q_b.push_back('{cyc: e, line: line, elem: elem, data: data});
      3: if (sub == 1) q_out.push_back('{cyc: e, row: line, col: elem});
         else push_compute(e, clr_bit(w));
      default: ;
    endcase
  endtask

  // Call just after a negedge; returns transfer edge index and cycles spent waiting for ready.
  task automatic issue(input logic [IW-1:0] w, output int e, output int waited);
    waited = 0;
    instr_valid = 1'b1;
    instr = w;
    while (!instr_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      chk("ready_timeout", instr_ready, 1);
      e = -1;
      instr_valid = 1'b0;
      return;
    end
    e = cyc + 1;
    model(w, e);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = IW'($urandom);
  endtask

  task automatic mon_step();
    wr_t  w;
    out_t o;
    ctl_t c;
    bit   exp_busy = 0, exp_we = 0, exp_dn = 0, exp_clr = 0;
    int   exp_en = 0, exp_el = 0;
    while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
      chk("mema_write_cycle", cyc, q_a[0].cyc);
      void'(q_a.pop_front());
    end
    if (mema_write_enable) begin
      if (q_a.size() == 0 || q_a[0].cyc != cyc) chk("mema_write_spurious", mema_write_enable, 0);
      else begin
        w = q_a.pop_front();
        chk("mema_write_line", mema_write_line, w.line);
        chk("mema_write_elem", mema_write_elem, w.elem);
        chk("mema_data_in", mema_data_in, w.data);
      end
    end
    while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
      chk("memb_write_cycle", cyc, q_b[0].cyc);
      void'(q_b.pop_front());
    end
    if (memb_write_enable) begin
      if (q_b.size() == 0 || q_b[0].cyc != cyc) chk("memb_write_spurious", memb_write_enable, 0);
      else begin
        w = q_b.pop_front();
        chk("memb_write_line", memb_write_line, w.line);
        chk("memb_write_elem", memb_write_elem, w.elem);
        chk("memb_data_in", memb_data_in, w.data);
      end
    end
    while (q_out.size() > 0 && q_out[0].cyc <= cyc) begin
      o = q_out.pop_front();
      exp_row = o.row;
      exp_col = o.col;
    end
    chk("array_output_row", array_output_row, exp_row);
    chk("array_output_column", array_output_column, exp_col);
    while (q_ctl.size() > 0 && q_ctl[0].cyc < cyc) begin
      chk("ctl_cycle", cyc, q_ctl[0].cyc);
      void'(q_ctl.pop_front());
    end
    if (q_ctl.size() > 0 && q_ctl[0].cyc == cyc) begin
      c = q_ctl.pop_front();
      exp_busy = 1;
      exp_we = c.we;
      exp_dn = c.dn;
      exp_clr = c.clr;
      exp_en = c.en;
      exp_el = c.elems;
    end
    chk("busy", busy, exp_busy);
    chk("instr_ready", instr_ready, !exp_busy);
    chk("done", done, exp_dn);
    chk("array_write_enable", array_write_enable, exp_we);
    chk("array_clear", array_clear_w, exp_clr);
    chk("mema_read_enable", mema_read_enable, exp_en);
    chk("memb_read_enable", memb_read_enable, exp_en);
    chk("mema_read_elem", mema_read_elem, exp_el);
    chk("memb_read_elem", memb_read_elem, exp_el);
  endtask

  always @(negedge clk) if (rst_n) mon_step();

  task automatic check_reset_outputs();
    chk("rst_instr_ready", instr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_array_we", array_write_enable, 0);
    chk("rst_array_clear", array_clear_w, 0);
    chk("rst_row_col", {array_output_row, array_output_column}, 0);
    chk("rst_mem_we", {mema_write_enable, memb_write_enable}, 0);
    chk("rst_mema_fields", {mema_write_line, mema_write_elem, mema_data_in}, 0);
    chk("rst_memb_fields", {memb_write_line, memb_write_elem, memb_data_in}, 0);
    chk("rst_read", {mema_read_enable, memb_read_enable, mema_read_elem, memb_read_elem}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, ec, wt, gap;
    logic [IW-1:0] w;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // LOAD_A line=1 elem=1 data=A7, OUTPUT row=2 col=0
    issue(16'h54A7, e, wt);
    @(negedge clk);
    issue(16'hE000, e, wt);
    @(negedge clk);
    // COMPUTE with a LOAD_B held behind it
    issue(16'hC000, ec, wt);
    @(negedge clk);
    issue(16'h9ABC, e, wt);
    chk("held_accept_cycle", e, ec + 3 * N + 1);
    @(negedge clk);
    issue(16'hC001, ec, wt);
    @(negedge clk);
    issue(16'h0000, e, wt);
    chk("held_accept_cycle_c001", e, ec + 3 * N + 1 + clr_bit(16'hC001));
    @(negedge clk);

    // Reset in the middle of FEED (t=3)
    issue(16'hC000, ec, wt);
    while (cyc < ec + 3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    q_a.delete();
    q_b.delete();
    q_out.delete();
    q_ctl.delete();
    exp_row = 0;
    exp_col = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    issue(16'h5C3D, e, wt);
    chk("post_reset_wait", wt, 0);
    @(negedge clk);

    for (int k = 0; k < 200; k++) begin
      w = IW'($urandom);
      issue(w, e, wt);
      gap = $urandom_range(0, 2);
      @(negedge clk);
      repeat (gap) @(negedge clk);
    end

    repeat (3 * N + 4) @(negedge clk);
    chk("mema_pending", q_a.size(), 0);
    chk("memb_pending", q_b.size(), 0);
    chk("ctl_pending", q_ctl.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
